arb_grant_responder: RTL and testbench
======================================

// Module: arb_grant_responder
// PURPOSE
//  Shared-resource end of the rotating-priority request/grant protocol.
//  Accepts the one-hot grant from the arbiter, latches the granted requester's
//  access, and runs a single valid/ready transaction on the shared memory port.
//  Returns read data or write ack to that requester as a one-cycle done pulse.
//  Drives the arbiter's enable so that a new grant is taken only when idle.
// PARAMETERS
//  WIDTH    2    number of requesters (matches arbiter WIDTH)
//  ADDR_W   32   address width
//  DATA_W   32   data width
//  TIMEOUT  64   max cycles in ISSUE+WAIT before error response (>=2)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               async active-low reset
//  grant      in   WIDTH           one-hot grant from arbiter
//  req_addr   in   WIDTH*ADDR_W    packed per-requester addr, req i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   WIDTH*DATA_W    packed per-requester write data
//  req_we     in   WIDTH           per-requester write enable
//  arb_enable out  1               to arbiter enable; 1 only in IDLE
//  busy       out  1               1 when state != IDLE
//  mem_valid  out  1               request valid to memory
//  mem_ready  in   1               memory accepts request
//  mem_addr   out  ADDR_W          latched address
//  mem_wdata  out  DATA_W          latched write data
//  mem_we     out  1               latched write enable
//  mem_rvalid in   1               read data valid / write ack
//  mem_rdata  in   DATA_W          read data
//  resp_done  out  WIDTH           one-hot done pulse to served requester
//  resp_rdata out  DATA_W          response data, held until next RESP
//  resp_err   out  1               timeout flag, valid with resp_done
// BEHAVIOUR
//  - Reset: state IDLE; mem_valid=0, resp_done=0, resp_err=0, resp_rdata=0,
//    mem_addr/wdata/we=0, timeout counter=0; arb_enable=1, busy=0.
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE; arb_enable/busy decoded from state.
//  - IDLE: if grant!=0, latch idx, addr, wdata, we of granted requester;
//    go ISSUE. Multi-hot grant: lowest set index served. Zero grant: stay.
//  - ISSUE: mem_valid=1, mem_addr/wdata/we stable; on mem_valid&mem_ready
//    -> WAIT. mem_rvalid ignored in ISSUE.
//  - WAIT: on mem_rvalid capture resp_rdata=mem_rdata (write: 0), err=0 -> RESP.
//  - Timeout: counter cleared on IDLE->ISSUE, +1 each ISSUE/WAIT cycle; when
//    counter==TIMEOUT-1 and no completing event that cycle -> RESP, err=1,
//    resp_rdata=0, mem_valid drops. Completion same cycle as timeout wins (err=0).
//  - RESP: exactly one cycle, resp_done[idx]=1, resp_err valid -> IDLE.
//  - Best-case latency: grant at cycle 0, mem_valid cycle 1 (ready=1), rvalid
//    cycle 2, resp_done cycle 3, arb_enable=1 cycle 4.
//  - grant/req_* sampled only in IDLE; changes in other states ignored.
//  - mem_rvalid in IDLE/RESP ignored; no state change.
//  - Reset mid-transaction aborts immediately; no resp_done issued for it.
//  - Counter width $clog2(TIMEOUT+1); no wrap possible before timeout fires.
// TESTING
//  T1 read: grant=2'b10, addr1=0x100, ready=1, rvalid cyc2 data 0xDEADBEEF ->
//     mem_addr=0x100 cyc1, resp_done=2'b10 cyc3 only, rdata=0xDEADBEEF, err=0.
//  T2 write stall: grant=2'b01, we0=1, wdata0=0x55AA, ready low 3 cycles ->
//     mem_valid/addr/wdata/we stable 4 cycles; after ack resp_done=2'b01, rdata=0.
//  T3 timeout: TIMEOUT=8, ready=1, rvalid never -> resp_done+err=1 on 8th cycle
//     after ISSUE entry, rdata=0, arb_enable=1 next cycle.
//  T4 race: TIMEOUT=8, rvalid with data 0x1234 on counter==7 -> err=0, rdata=0x1234.
//  T5 reset in WAIT: rst low 1 cycle -> all outputs at reset values, no done;
//     later stray rvalid in IDLE -> no resp_done, state IDLE.
//  T6 illegal grant 2'b11 -> requester 0 served; back-to-back with arbiter
//     (req=2'b11 held): grants alternate 0,1,0, exactly one done per grant.

Source files
------------

// File: rtl/arb_grant_responder.sv
// arb_grant_responder
//   Shared-resource side of the rotating-priority request/grant protocol.
//   Takes a one-hot grant from the arbiter and latches the granted requester's
//   address, write data and write enable. It then runs one valid/ready request
//   on the memory port and waits for rvalid (read data or write ack). The
//   result goes back to that requester as a one-cycle done pulse. The arbiter
//   enable is high only while idle, so a new grant is accepted only between
//   transactions.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   grant_i      one-hot grant from the arbiter (multi-hot: lowest index wins)
//   req_addr_i   packed per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata_i  packed per-requester write data, requester i at [i*DATA_W +: DATA_W]
//   req_we_i     per-requester write enable
//   arb_enable_o enable to the arbiter, high only in IDLE
//   busy_o       high whenever a transaction is in progress
//   mem_valid_o  request valid to memory
//   mem_ready_i  memory accepts the request
//   mem_addr_o   latched address
//   mem_wdata_o  latched write data
//   mem_we_o     latched write enable
//   mem_rvalid_i read data valid / write ack
//   mem_rdata_i  read data
//   resp_done_o  one-hot done pulse to the served requester
//   resp_rdata_o response data, held until the next response
//   resp_err_o   timeout flag, valid with resp_done_o
module arb_grant_responder #(
  parameter int WIDTH   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        grant_i,
  input  logic [WIDTH*ADDR_W-1:0] req_addr_i,
  input  logic [WIDTH*DATA_W-1:0] req_wdata_i,
  input  logic [WIDTH-1:0]        req_we_i,
  output logic                    arb_enable_o,
  output logic                    busy_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic                    mem_we_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  output logic [WIDTH-1:0]        resp_done_o,
  output logic [DATA_W-1:0]       resp_rdata_o,
  output logic                    resp_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [WIDTH-1:0]  resp_done_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  // Isolate the lowest set grant bit so a multi-hot grant still selects
  // exactly one requester.
  logic [WIDTH-1:0]  sel_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              timeout_hit;

  assign sel_oh = grant_i & (~grant_i + WIDTH'(1));

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_oh[i]) begin
        sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
        sel_we    = req_we_i[i];
      end
    end
  end

  assign cnt_d       = cnt_q + CNT_W'(1);
  // Last cycle allowed in ISSUE+WAIT; a completion in this same cycle still wins.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      resp_done_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|grant_i) begin
            idx_q       <= sel_oh;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we;
            cnt_q       <= '0;
            mem_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A handshake landing on the timeout cycle cannot complete the
          // transaction (no data yet), so the timeout takes precedence here.
          if (timeout_hit) begin
            mem_valid_q  <= 1'b0;
            resp_done_q  <= idx_q;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
            if (mem_ready_i) begin
              mem_valid_q <= 1'b0;
              state_q     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            resp_done_q  <= idx_q;
            resp_rdata_q <= mem_we_q ? '0 : mem_rdata_i;
            resp_err_q   <= 1'b0;
            state_q      <= S_RESP;
          end else if (timeout_hit) begin
            resp_done_q  <= idx_q;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign arb_enable_o = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
  assign resp_done_o  = resp_done_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_arb_grant_responder.sv
// Testbench for arb_grant_responder (WIDTH=2, TIMEOUT=8).
// Each transaction is described by its grant, the number of cycles ready is
// held low (r) and the number of WAIT cycles before rvalid (v). The expected
// cycle-by-cycle behaviour is derived arithmetically from those numbers.
module tb_arb_grant_responder;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic [1:0]  grant;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_we;
  logic        arb_enable;
  logic        busy;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  resp_done;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests;
  int fails;
  logic [31:0] last_rdata;
  int arb_ptr;

  arb_grant_responder #(.WIDTH(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .grant_i(grant), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_we_i(req_we), .arb_enable_o(arb_enable),
    .busy_o(busy), .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .resp_done_o(resp_done),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_quiet();
    grant      = 2'b00;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // One transaction starting at the current negedge (cycle 0, DUT idle).
  // Returns at the negedge of the first idle cycle after the response.
  task automatic run_txn(input string name, input logic [1:0] g,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [1:0] we, input int r, input int v,
                         input logic [31:0] rd);
    int idx, c_cyc, d_cyc;
    bit ok;
    logic [31:0] e_addr, e_wdata, e_rdata, rnd;
    logic e_we, e_valid, e_en;
    logic [1:0] e_done, e_oh;
    idx = -1;
    for (int i = 0; i < 2; i++) if (g[i] && idx < 0) idx = i;
    e_oh = '0;
    e_oh[idx] = 1'b1;
    e_addr  = (idx == 1) ? a1 : a0;
    e_wdata = (idx == 1) ? w1 : w0;
    e_we    = we[idx];
    c_cyc   = 2 + r + v;          // cycle rvalid is presented
    ok      = (c_cyc <= TMO);     // counter at that cycle is c_cyc-1
    d_cyc   = ok ? c_cyc + 1 : TMO + 1;
    e_rdata = (ok && !e_we) ? rd : 32'h0;
    for (int k = 0; k <= d_cyc; k++) begin
      e_en    = (k == 0);
      e_valid = (k >= 1) && (k <= 1 + r) && (k <= TMO);
      e_done  = (k == d_cyc) ? e_oh : 2'b00;
      tests++;
      if (arb_enable !== e_en || busy !== !e_en) begin
        fails++;
        $display("FAIL %s enable/busy k=%0d got en=%b busy=%b exp en=%b", name, k, arb_enable, busy, e_en);
      end
      tests++;
      if (mem_valid !== e_valid) begin
        fails++;
        $display("FAIL %s mem_valid k=%0d got %b exp %b", name, k, mem_valid, e_valid);
      end
      tests++;
      if (resp_done !== e_done) begin
        fails++;
        $display("FAIL %s resp_done k=%0d got %b exp %b", name, k, resp_done, e_done);
      end
      if (k >= 1) begin
        tests++;
        if (mem_addr !== e_addr || mem_wdata !== e_wdata || mem_we !== e_we) begin
          fails++;
          $display("FAIL %s mem_req k=%0d got %h/%h/%b exp %h/%h/%b", name, k,
                   mem_addr, mem_wdata, mem_we, e_addr, e_wdata, e_we);
        end
      end
      if (k == d_cyc) begin
        tests++;
        if (resp_rdata !== e_rdata || resp_err !== !ok) begin
          fails++;
          $display("FAIL %s resp k=%0d got rdata=%h err=%b exp rdata=%h err=%b", name, k,
                   resp_rdata, resp_err, e_rdata, !ok);
        end
      end
      // Drive cycle k; outside cycle 0 the request side carries noise.
      if (k == 0) begin
        grant     = g;
        req_addr  = {a1, a0};
        req_wdata = {w1, w0};
        req_we    = we;
      end else begin
        rnd = $urandom;
        grant     = rnd[1:0];
        req_we    = rnd[3:2];
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
      end
      rnd = $urandom;
      mem_ready  = (k >= 1 + r);
      mem_rvalid = (k == c_cyc) || (k >= 1 && k <= 1 + r && rnd[0]) || (k == d_cyc && rnd[1]);
      mem_rdata  = (k == c_cyc) ? rd : $urandom;
      @(negedge clk);
    end
    drive_quiet();
    last_rdata = e_rdata;
    $display("[TB] txn %s grant=%b served=%0d we=%b r=%0d v=%0d err=%b rdata=%h",
             name, g, idx, e_we, r, v, !ok, resp_rdata);
  endtask

  task automatic idle_cycles(input string name, input int n);
    logic [31:0] rnd;
    for (int k = 0; k < n; k++) begin
      tests++;
      if (arb_enable !== 1'b1 || busy !== 1'b0 || mem_valid !== 1'b0 || resp_done !== 2'b00 ||
          resp_rdata !== last_rdata) begin
        fails++;
        $display("FAIL %s idle k=%0d got en=%b busy=%b valid=%b done=%b rdata=%h exp rdata=%h",
                 name, k, arb_enable, busy, mem_valid, resp_done, resp_rdata, last_rdata);
      end
      rnd = $urandom;
      grant      = 2'b00;
      mem_ready  = rnd[0];
      mem_rvalid = rnd[1];   // stray rvalid while idle must be ignored
      mem_rdata  = $urandom;
      @(negedge clk);
    end
    drive_quiet();
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if (arb_enable !== 1'b1 || busy !== 1'b0 || mem_valid !== 1'b0 || resp_done !== 2'b00 ||
        resp_err !== 1'b0 || resp_rdata !== 32'h0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL %s reset_values got en=%b busy=%b valid=%b done=%b err=%b rdata=%h addr=%h wdata=%h we=%b",
               name, arb_enable, busy, mem_valid, resp_done, resp_err, resp_rdata,
               mem_addr, mem_wdata, mem_we);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_quiet();
    req_addr = '0; req_wdata = '0; req_we = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    last_rdata = 32'h0;
    idle_cycles("reset_idle", 2);
  endtask

  task automatic test_read();
    run_txn("t1_read", 2'b10, 32'h0, 32'h100, 32'h0, 32'h0, 2'b00, 0, 0, 32'hDEADBEEF);
    idle_cycles("t1_idle", 1);
  endtask

  task automatic test_write_stall();
    run_txn("t2_write", 2'b01, 32'hA000, 32'hB000, 32'h55AA, 32'h1111, 2'b01, 3, 1, 32'hCAFEF00D);
    idle_cycles("t2_idle", 1);
  endtask

  task automatic test_timeout();
    run_txn("t3_timeout", 2'b01, 32'h40, 32'h80, 32'h0, 32'h0, 2'b00, 0, 100, 32'h0);
    idle_cycles("t3_idle", 1);
  endtask

  task automatic test_race();
    run_txn("t4_race", 2'b10, 32'h44, 32'h88, 32'h0, 32'h0, 2'b00, 2, 4, 32'h1234);
    idle_cycles("t4_idle", 1);
  endtask

  task automatic test_reset_mid();
    grant = 2'b01; req_addr = {32'h0, 32'h300}; req_we = 2'b00;
    @(negedge clk);                  // ISSUE
    grant = 2'b00; mem_ready = 1'b1;
    @(negedge clk);                  // WAIT
    mem_ready = 1'b0;
    tests++;
    if (busy !== 1'b1 || mem_addr !== 32'h300) begin
      fails++;
      $display("FAIL t5 pre_reset got busy=%b addr=%h exp busy=1 addr=00000300", busy, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    idle_cycles("t5_stray", 5);
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
    run_txn("t6_multihot", 2'b11, 32'h600, 32'h700, 32'h0, 32'h0, 2'b00, 1, 0, 32'h600D);
    arb_ptr = 0;
    for (int n = 0; n < 3; n++) begin
      // Rotating-priority arbiter with both requests held: grant the pointer, then advance.
      g = '0;
      g[arb_ptr] = 1'b1;
      tests++;
      if (g !== exp_seq[n]) begin
        fails++;
        $display("FAIL t6 arb_order n=%0d got %b exp %b", n, g, exp_seq[n]);
      end
      run_txn("t6_b2b", g, 32'h10 + n, 32'h20 + n, 32'h0, 32'h0, 2'b00, 0, n, $urandom);
      arb_ptr = (arb_ptr + 1) % 2;
    end
    idle_cycles("t6_idle", 1);
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    logic [1:0] g;
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom;
      g = (rnd[1:0] == 2'b00) ? 2'b01 : rnd[1:0];
      run_txn("rand", g, $urandom, $urandom, $urandom, $urandom, rnd[3:2],
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), $urandom);
      if (rnd[4]) idle_cycles("rand_idle", 1);
    end
    idle_cycles("rand_end", 1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    last_rdata = 32'h0;
    arb_ptr = 0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write_stall();
    test_timeout();
    test_race();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
